fetch_unit: RTL

Parametrised instruction-fetch front end for the five-stage RISC-V core. It replaces the single-entry PC register, PC adder, PC mux and IF/ID latch with a DEPTH-entry prefetch queue. It talks to a variable-latency instruction memory through a request/response handshake. It presents instructions to decode with valid/ready, and squashes in-flight fetches on a branch/jump redirect.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order tag FIFO and DEPTH-entry prefetch queue.
// Optional FETCH_PERF_EN macro adds saturating perf_fetched / perf_squashed counters.
module fetch_unit #(
  parameter int PC_W = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           imem_req_valid,
  output logic [PC_W-1:0]                imem_req_addr,
  input  logic                           imem_req_ready,
  input  logic                           imem_rsp_valid,
  input  logic [INS_W-1:0]               imem_rsp_data,
  input  logic                           redirect,
  input  logic [PC_W-1:0]                redirect_pc,
  input  logic                           halt,
  output logic                           id_valid,
  output logic [PC_W-1:0]                id_pc,
  output logic [INS_W-1:0]               id_instr,
  input  logic                           id_ready,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                    perf_fetched,
  output logic [31:0]                    perf_squashed
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [AW-1:0]    q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [AW-1:0]    t_head_q, t_head_d, t_tail_q, t_tail_d;

  logic [PC_W-1:0]  q_pc_mem  [DEPTH];
  logic [INS_W-1:0] q_ins_mem [DEPTH];
  logic [PC_W-1:0]  tag_mem   [DEPTH];

  logic [CW:0]      credit_sum;
  logic             accept, pop, rsp_drop, push;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign credit_sum     = (CW+1)'(occ_q) + (CW+1)'(outst_q);
  assign imem_req_valid = reset && !redirect && !halt && (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pop            = (occ_q != '0) && id_ready;
  // A response is discarded if it belongs to a squashed stream or lands in the redirect cycle.
  assign rsp_drop       = imem_rsp_valid && (redirect || (drop_q != '0));
  assign push           = imem_rsp_valid && !rsp_drop;

  assign id_valid  = (occ_q != '0);
  assign id_pc     = id_valid ? q_pc_mem[q_head_q] : '0;
  assign id_instr  = id_valid ? q_ins_mem[q_head_q] : '0;
  assign occupancy = occ_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    q_head_d   = q_head_q;
    q_tail_d   = q_tail_q;
    t_head_d   = imem_rsp_valid ? t_head_q + 1'b1 : t_head_q;
    t_tail_d   = accept ? t_tail_q + 1'b1 : t_tail_q;
    if (accept) begin
      fetch_pc_d = fetch_pc_q + PC_W'(4);
    end
    if (redirect) begin
      occ_d      = '0;
      q_head_d   = '0;
      q_tail_d   = '0;
      drop_d     = outst_q - CW'(imem_rsp_valid);
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else begin
      occ_d = occ_q + CW'(push) - CW'(pop);
      if (push) begin
        q_tail_d = q_tail_q + 1'b1;
      end
      if (pop) begin
        q_head_d = q_head_q + 1'b1;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      q_head_q   <= '0;
      q_tail_q   <= '0;
      t_head_q   <= '0;
      t_tail_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      q_head_q   <= q_head_d;
      q_tail_q   <= q_tail_d;
      t_head_q   <= t_head_d;
      t_tail_q   <= t_tail_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked entirely by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[t_tail_q] <= fetch_pc_q;
    end
    if (push) begin
      q_pc_mem[q_tail_q]  <= tag_mem[t_head_q];
      q_ins_mem[q_tail_q] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, squashed_q, squashed_d;
  logic [32:0] fetched_sum, squashed_sum;
  logic [CW-1:0] flushed;

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;

  always_comb begin
    flushed      = redirect ? occ_q - CW'(pop) : '0;
    fetched_sum  = {1'b0, fetched_q} + 33'(push);
    squashed_sum = {1'b0, squashed_q} + 33'(rsp_drop) + 33'(flushed);
    fetched_d    = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    squashed_d   = squashed_sum[32] ? 32'hFFFF_FFFF : squashed_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end
`endif

endmodule
